read_request_dispatcher: RTL and testbench
==========================================

// Module: read_request_dispatcher
// PURPOSE
// - Pops read requests from the read request FIFO and holds one request at a time.
// - Routes each held request to its target bank controller over a per-bank valid/ready handshake.
// - Keeps a per-bank credit count of outstanding reads, plus an open-row table that flags row hits.
// - Sits directly downstream of the read request FIFO; throughput is one request per cycle when unstalled.
// PARAMETERS
// BANK_NUM         4   number of bank controllers (power of 2)
// BANK_BITS        2   $clog2(BANK_NUM)
// ROW_BITS        14   row address width
// COL_BITS        10   column address width
// ID_BITS          4   request tag width
// MAX_OUTSTANDING  8   per-bank credit limit; credit counter is $clog2(MAX_OUTSTANDING+1) bits
// PORTS
// i_clk          in   1          clock
// i_rst_n        in   1          reset, synchronous, active-low
// i_fifo_data    in   read_req_t FIFO head, valid while !i_fifo_empty (first-word fall-through)
// i_fifo_empty   in   1          FIFO empty flag
// o_fifo_rd_en   out  1          pop FIFO head this cycle
// o_bank_valid   out  BANK_NUM   one-hot request valid, one bit per bank
// o_bank_req     out  read_req_t held request, broadcast to all banks
// o_row_hit      out  1          held request hits the open row of its bank; qualified by |o_bank_valid
// i_bank_ready   in   BANK_NUM   bank accepts request
// i_bank_done    in   BANK_NUM   1-cycle pulse: bank completed one read, credit returned
// o_idle         out  1          no held request and all credits at MAX_OUTSTANDING
// o_credit_err   out  1          sticky: done received while credit already at MAX_OUTSTANDING
// BEHAVIOUR
// - Reset (i_rst_n==0 at posedge; synchronous):
//   - FSM goes to S_IDLE; the held request is discarded.
//   - Every credit is set to MAX_OUTSTANDING; every row_valid is cleared; o_credit_err=0.
//   - Reset also applies mid-handshake: the held request is dropped, not replayed.
// - Outputs during reset: o_bank_valid=0, o_fifo_rd_en=0, o_row_hit=0, o_bank_req=0, o_idle=1.
// - FSM states:
//   - S_IDLE, no held request:
//     - If !i_fifo_empty: o_fifo_rd_en=1, capture i_fifo_data into hold_q, go to S_HOLD.
//   - S_HOLD, request held:
//     - b = hold_q.bank.
//     - o_bank_valid[b] = (credit[b]!=0); all other bits are 0.
//     - fire = o_bank_valid[b] && i_bank_ready[b].
//     - On fire with !i_fifo_empty: pop and capture the next request in the same cycle; stay in S_HOLD (back-to-back).
//     - On fire with i_fifo_empty: go to S_IDLE.
//     - Without fire: hold_q stays stable and o_fifo_rd_en=0.
// - o_fifo_rd_en is combinational: !i_fifo_empty && (state==S_IDLE || fire). It is never asserted while the FIFO is empty.
// - Latency: FIFO non-empty at cycle t gives pop at t, and o_bank_valid at t+1 if a credit exists.
// - Valid stability: once o_bank_valid[b] rises, it holds with a stable o_bank_req until fire. Only fire decrements credit[b], so valid cannot drop before fire.
// - Credits:
//   - Per bank b: credit += i_bank_done[b]; credit -= fire_b.
//   - fire and done on the same bank in the same cycle leave credit unchanged.
//   - done at MAX_OUTSTANDING (with no fire) is ignored and sets o_credit_err.
//   - At credit 0, the request stalls at the dispatcher (head-of-line blocking is intended; reads stay in order).
// - Open-row table:
//   - o_row_hit = row_valid[b] && open_row[b]==hold_q.row (combinational).
//   - On fire: open_row[b] <= hold_q.row and row_valid[b] <= 1.
// - o_idle = (state==S_IDLE) && all credits == MAX_OUTSTANDING.
// - Width rules: counters saturate at both ends as above, with no wrap.
// STRUCTURE
// - frontend_command_definition_pkg holds:
//   - typedef struct packed {id, bank, row, col} read_req_t;
//   - BANK_BITS/ROW_BITS/COL_BITS/ID_BITS localparams;
//   - the disp_state_e enum {S_IDLE, S_HOLD}.
// - Sub-module bank_credit_counter (one instance per bank, generate loop):
//   - ports: inc, dec, count, zero, full, err.
//   - Everything else stays flat in this module.
// TESTING
// - Single read, bank 2, row 0x1A, ready tied 1 -> pop at t; o_bank_valid=4'b0100 at t+1; fire; o_row_hit=0; credit[2]=7.
// - Second read to bank 2, row 0x1A -> o_row_hit=1. Then row 0x1B -> o_row_hit=0 and open_row[2]=0x1B.
// - 10 reads to bank 0, no done pulses -> 8 fire; the 9th is held with o_bank_valid=0. Then one i_bank_done[0] pulse -> the 9th fires next cycle.
// - 4 queued reads to banks 0,1,2,3 with all ready -> o_fifo_rd_en high 4 consecutive cycles; one fire per cycle, in order.
// - Same-cycle fire and done on bank 1 at credit 5 -> credit stays 5. done on bank 3 at credit 8 -> o_credit_err=1 (sticky).
// - i_bank_ready low for 5 cycles -> o_bank_req and o_bank_valid stable. Reset asserted in cycle 3 -> next cycle all outputs at reset values and credits at 8.

Source files
------------

// File: rtl/frontend_command_definition_pkg.sv
// frontend_command_definition_pkg: read request format, sizing constants and dispatcher states
package frontend_command_definition_pkg;
    localparam int BANK_NUM        = 4;
    localparam int BANK_BITS       = $clog2(BANK_NUM);
    localparam int ROW_BITS        = 14;
    localparam int COL_BITS        = 10;
    localparam int ID_BITS         = 4;
    localparam int MAX_OUTSTANDING = 8;
    localparam int CREDIT_BITS     = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ID_BITS-1:0]   id;
        logic [BANK_BITS-1:0] bank;
        logic [ROW_BITS-1:0]  row;
        logic [COL_BITS-1:0]  col;
    } read_req_t;

    typedef enum logic {S_IDLE, S_HOLD} disp_state_e;
endpackage

// File: rtl/bank_credit_counter.sv
// bank_credit_counter: saturating outstanding-read credit for one bank with a sticky overflow flag
module bank_credit_counter
    import frontend_command_definition_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   inc,
    input  logic                   dec,
    output logic [CREDIT_BITS-1:0] count,
    output logic                   zero,
    output logic                   full,
    output logic                   err
);
    assign zero = count == '0;
    assign full = count == CREDIT_BITS'(MAX_OUTSTANDING);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count <= CREDIT_BITS'(MAX_OUTSTANDING);
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (full) err <= 1'b1;
            else count <= count + CREDIT_BITS'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - CREDIT_BITS'(1);
        end
    end
endmodule

// File: rtl/read_request_dispatcher.sv
// read_request_dispatcher: pops FIFO read requests and dispatches them in order to credit-limited banks
module read_request_dispatcher
    import frontend_command_definition_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  read_req_t           i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd_en,
    output logic [BANK_NUM-1:0] o_bank_valid,
    output read_req_t           o_bank_req,
    output logic                o_row_hit,
    input  logic [BANK_NUM-1:0] i_bank_ready,
    input  logic [BANK_NUM-1:0] i_bank_done,
    output logic                o_idle,
    output logic                o_credit_err
);
    disp_state_e            state;
    read_req_t              hold_q;
    logic [ROW_BITS-1:0]    open_row [BANK_NUM];
    logic [CREDIT_BITS-1:0] credit [BANK_NUM];
    logic [BANK_NUM-1:0]    row_valid, fire_vec, zero, full, err;
    logic [BANK_BITS-1:0]   b;
    logic                   held, fire;

    // Every output is forced to its reset value while reset is asserted
    assign b            = hold_q.bank;
    assign held         = i_rst_n && state == S_HOLD;
    assign o_bank_valid = (held && !zero[b]) ? BANK_NUM'(1) << b : '0;
    assign fire_vec     = o_bank_valid & i_bank_ready;
    assign fire         = |fire_vec;
    assign o_fifo_rd_en = i_rst_n && !i_fifo_empty && (state == S_IDLE || fire);
    assign o_bank_req   = i_rst_n ? hold_q : '0;
    assign o_row_hit    = held && row_valid[b] && open_row[b] == hold_q.row;
    assign o_idle       = !i_rst_n || (state == S_IDLE && &full);
    assign o_credit_err = i_rst_n && |err;

    for (genvar i = 0; i < BANK_NUM; i++) begin : g_credit
        bank_credit_counter u_credit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .inc     (i_bank_done[i]),
            .dec     (fire_vec[i]),
            .count   (credit[i]),
            .zero    (zero[i]),
            .full    (full[i]),
            .err     (err[i])
        );
        always_ff @(posedge i_clk) begin : p_bound
            if (i_rst_n) assert (credit[i] <= CREDIT_BITS'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            hold_q    <= '0;
            row_valid <= '0;
        end else begin
            if (o_fifo_rd_en) begin
                state  <= S_HOLD;
                hold_q <= i_fifo_data;
            end else if (fire) begin
                state <= S_IDLE;
            end
            if (fire) begin
                open_row[b]  <= hold_q.row;
                row_valid[b] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_read_request_dispatcher.sv
// tb_read_request_dispatcher: scoreboard bench with an abstract credit/queue reference model
module tb_read_request_dispatcher;
    import frontend_command_definition_pkg::*;

    typedef struct {read_req_t req; logic hit;} exp_t;

    logic clk = 1'b0, rst_n = 1'b0, fifo_empty = 1'b1;
    logic fifo_rd_en, row_hit, idle, credit_err;
    read_req_t fifo_data = '0, bank_req;
    logic [BANK_NUM-1:0] bank_valid, rdy = '1, done = '0;

    read_req_t fifo[$];
    exp_t exp_q[$];
    logic hit_log[$];
    int cred[BANK_NUM];
    int fire_cnt[BANK_NUM];
    bit lv[BANK_NUM];
    logic [ROW_BITS-1:0] lr[BANK_NUM];
    logic held = 1'b0, merr = 1'b0;
    logic [BANK_BITS-1:0] hb = '0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    read_request_dispatcher dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (fifo_rd_en),
        .o_bank_valid (bank_valid),
        .o_bank_req   (bank_req),
        .o_row_hit    (row_hit),
        .i_bank_ready (rdy),
        .i_bank_done  (done),
        .o_idle       (idle),
        .o_credit_err (credit_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit all_full();
        foreach (cred[i]) if (cred[i] != MAX_OUTSTANDING) return 1'b0;
        return 1'b1;
    endfunction

    task automatic refresh();
        fifo_empty = fifo.size() == 0;
        fifo_data  = fifo_empty ? '0 : fifo[0];
    endtask

    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        done = '0;
        refresh();
    endtask

    // Requests dispatch strictly in order, so the row hit is known when the request is queued
    task automatic push(input int bank, input int row);
        read_req_t r;
        r.id   = ID_BITS'($urandom);
        r.col  = COL_BITS'($urandom);
        r.bank = BANK_BITS'(bank);
        r.row  = ROW_BITS'(row);
        fifo.push_back(r);
        exp_q.push_back('{r, lv[bank] && lr[bank] == r.row});
        lv[bank] = 1'b1;
        lr[bank] = r.row;
        refresh();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int bank);
        int n = 0;
        #1;
        while (bank_valid[bank] !== 1'b1 && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("wait_valid", bank_valid[bank], 1);
    endtask

    always @(negedge clk) begin
        logic ef, er, dec;
        logic [BANK_NUM-1:0] ev;
        exp_t e;
        if (!rst_n) begin
            chk("rst_valid", bank_valid, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_hit", row_hit, 0);
            chk("rst_req", bank_req, 0);
            chk("rst_idle", idle, 1);
            chk("rst_err", credit_err, 0);
            held = 1'b0;
            merr = 1'b0;
            foreach (cred[i]) cred[i] = MAX_OUTSTANDING;
        end else begin
            ef = held && cred[hb] != 0 && rdy[hb];
            ev = (held && cred[hb] != 0) ? BANK_NUM'(1) << hb : '0;
            er = fifo.size() != 0 && (!held || ef);
            chk("bank_valid", bank_valid, ev);
            chk("fifo_rd_en", fifo_rd_en, er);
            chk("idle", idle, !held && all_full());
            chk("credit_err", credit_err, merr);
            if (held && exp_q.size() != 0) begin
                chk("held_req", bank_req, exp_q[0].req);
                chk("row_hit", row_hit, exp_q[0].hit);
            end
            if ((bank_valid & rdy) != 0) begin
                if (exp_q.size() == 0) chk("fire_unexpected", bank_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("fire_req", bank_req, e.req);
                    chk("fire_hit", row_hit, e.hit);
                    fire_cnt[e.req.bank]++;
                    hit_log.push_back(row_hit);
                end
            end
            for (int i = 0; i < BANK_NUM; i++) begin
                dec = ef && hb == i;
                if (done[i] && !dec) begin
                    if (cred[i] == MAX_OUTSTANDING) merr = 1'b1;
                    else cred[i]++;
                end else if (dec && !done[i]) begin
                    cred[i]--;
                end
            end
            if (er) begin
                held = 1'b1;
                hb   = fifo[0].bank;
            end else if (ef) begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [BANK_NUM-1:0] v0;
        read_req_t q0;
        int base;
        refresh();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        #1 chk("idle_after_reset", idle, 1);

        // Single read to bank 2 then row hit / miss sequence
        push(2, 'h1A);
        #1 chk("lat_rd_en", fifo_rd_en, 1);
        tick();
        #1 chk("lat_valid", bank_valid, 4'b0100);
        drain(10);
        chk("t1_hit", hit_log[$], 0);
        push(2, 'h1A);
        drain(10);
        chk("t2_hit", hit_log[$], 1);
        push(2, 'h1B);
        drain(10);
        chk("t3_miss", hit_log[$], 0);
        push(2, 'h1B);
        drain(10);
        chk("t4_open_row", hit_log[$], 1);
        repeat (4) begin
            done = 4'b0100;
            tick();
        end
        tick();
        #1 chk("b2_idle", idle, 1);

        // Credit exhaustion on bank 0
        base = fire_cnt[0];
        repeat (10) push(0, $urandom_range(0, 15));
        repeat (20) tick();
        #1 chk("b0_fired", fire_cnt[0] - base, 8);
        chk("b0_stall_valid", bank_valid, 0);
        done = 4'b0001;
        tick();
        tick();
        #1 chk("b0_ninth", fire_cnt[0] - base, 9);
        repeat (9) begin
            done = 4'b0001;
            tick();
        end
        tick();
        #1 chk("b0_idle", idle, 1);

        // Back-to-back dispatch to all banks
        for (int i = 0; i < BANK_NUM; i++) push(i, 'h100 + i);
        #1;
        for (int i = 0; i < BANK_NUM; i++) begin
            chk("b2b_rd_en", fifo_rd_en, 1);
            tick();
            #1;
        end
        chk("b2b_rd_end", fifo_rd_en, 0);
        tick();
        done = '1;
        tick();
        tick();
        #1 chk("b2b_idle", idle, 1);

        // Fire and done on the same bank in one cycle, then overflow on bank 3
        repeat (3) push(1, 7);
        drain(10);
        rdy[1] = 1'b0;
        push(1, 9);
        wait_valid(1);
        rdy[1] = 1'b1;
        done = 4'b0010;
        tick();
        repeat (3) begin
            done = 4'b0010;
            tick();
        end
        tick();
        #1 chk("b1_credit_kept", idle, 1);
        done = 4'b1000;
        tick();
        #1 chk("err_set", credit_err, 1);
        repeat (3) tick();
        #1 chk("err_sticky", credit_err, 1);

        // Stall with ready low, then reset mid-handshake
        rdy[3] = 1'b0;
        push(3, 'h33);
        wait_valid(3);
        v0 = bank_valid;
        q0 = bank_req;
        repeat (3) begin
            tick();
            #1 chk("stall_valid", bank_valid, v0);
            chk("stall_req", bank_req, q0);
        end
        rst_n = 1'b0;
        push(3, 'h34);
        tick();
        #1 chk("rst_mid_valid", bank_valid, 0);
        chk("rst_mid_rd_en", fifo_rd_en, 0);
        chk("rst_mid_req", bank_req, 0);
        chk("rst_mid_idle", idle, 1);
        fifo.delete();
        exp_q.delete();
        foreach (lv[i]) lv[i] = 1'b0;
        refresh();
        rdy = '1;
        rst_n = 1'b1;
        tick();
        #1 chk("post_rst_idle", idle, 1);
        chk("post_rst_err", credit_err, 0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) != 0 && fifo.size() < 6) push($urandom_range(0, 3), $urandom_range(0, 3));
            rdy = BANK_NUM'($urandom);
            for (int i = 0; i < BANK_NUM; i++) done[i] = cred[i] < MAX_OUTSTANDING && $urandom_range(0, 3) == 0;
            tick();
        end
        rdy = '1;
        for (int n = 0; n < 400 && (exp_q.size() != 0 || !all_full()); n++) begin
            for (int i = 0; i < BANK_NUM; i++) done[i] = cred[i] < MAX_OUTSTANDING;
            tick();
        end
        chk("rand_drain", exp_q.size(), 0);
        tick();
        #1 chk("rand_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
